// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - write-back arbiter for the 8 x 16-bit register set
//
// Two requesters share the register set's single write port:
//   requester 0 = ALU write-back, requester 1 = memory/load write-back.
// One requester is granted per cycle. The winner's destination is decoded to
// a one-hot select, and a registered regWrite/decOut/writeData triple drives
// the register set. A saturating stall counter records contention.
//
// Optional feature macro: WB_RR_PRIORITY_EN
//   defined     : round-robin tie-break (requester != lastGrant wins)
//   not defined : fixed priority, requester 1 (MEM) always wins ties
//
// Ports:
//   clk                     in   single clock, rising edge
//   reset                   in   asynchronous, active-high
//   reqValid0/1             in   requester has a write pending
//   reqAddr0/1   [2:0]      in   destination register index
//   reqData0/1   [15:0]     in   write data
//   reqReady0/1             out  requester accepted this cycle (combinational)
//   regWrite                out  register-set write enable (registered)
//   decOut       [7:0]      out  one-hot destination select (registered)
//   writeData    [15:0]     out  register-set write data (registered)
//   stallCount   [7:0]      out  saturating count of stalled cycles

module reg_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid0,
  input  logic [2:0]  reqAddr0,
  input  logic [15:0] reqData0,
  output logic        reqReady0,
  input  logic        reqValid1,
  input  logic [2:0]  reqAddr1,
  input  logic [15:0] reqData1,
  output logic        reqReady1,
  output logic        regWrite,
  output logic [7:0]  decOut,
  output logic [15:0] writeData,
  output logic [7:0]  stallCount
);

  logic        lastGrant_q, lastGrant_d;
  logic        wr_q, wr_d;
  logic [7:0]  dec_q, dec_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  stall_q, stall_d;

  logic        grant0, grant1;
  logic        xfer;
  logic        stall;
  logic [2:0]  addr_sel;
  logic [15:0] data_sel;

  // Grants depend only on the valids and lastGrant, never on addr/data.
  // Both readies are held low during reset so nothing is accepted then.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (reqValid0 && !reqValid1) begin
        grant0 = 1'b1;
      end else if (reqValid1 && !reqValid0) begin
        grant1 = 1'b1;
      end else if (reqValid0 && reqValid1) begin
`ifdef WB_RR_PRIORITY_EN
        // The requester that did not win last time takes the tie.
        grant0 = lastGrant_q;
        grant1 = !lastGrant_q;
`else
        grant1 = 1'b1;
`endif
      end
    end
  end

  assign reqReady0 = grant0;
  assign reqReady1 = grant1;

  always_comb begin
    xfer        = grant0 || grant1;
    addr_sel    = grant1 ? reqAddr1 : reqAddr0;
    data_sel    = grant1 ? reqData1 : reqData0;
    stall       = (reqValid0 && !grant0) || (reqValid1 && !grant1);

    // lastGrant is tracked in both builds; fixed priority simply ignores it.
    lastGrant_d = xfer ? grant1 : lastGrant_q;

    wr_d        = xfer;
    dec_d       = xfer ? (8'd1 << addr_sel) : 8'h00;
    data_d      = xfer ? data_sel : data_q;

    stall_d     = stall_q;
    if (stall && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_q <= 1'b1;
      wr_q        <= 1'b0;
      dec_q       <= 8'h00;
      data_q      <= 16'h0000;
      stall_q     <= 8'h00;
    end else begin
      lastGrant_q <= lastGrant_d;
      wr_q        <= wr_d;
      dec_q       <= dec_d;
      data_q      <= data_d;
      stall_q     <= stall_d;
    end
  end

  assign regWrite   = wr_q;
  assign decOut     = dec_q;
  assign writeData  = data_q;
  assign stallCount = stall_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - scoreboard bench for reg_wb_arbiter

module tb_reg_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        reqValid0, reqValid1;
  logic [2:0]  reqAddr0, reqAddr1;
  logic [15:0] reqData0, reqData1;
  logic        reqReady0, reqReady1;
  logic        regWrite;
  logic [7:0]  decOut;
  logic [15:0] writeData;
  logic [7:0]  stallCount;

  reg_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .reqValid0  (reqValid0),
    .reqAddr0   (reqAddr0),
    .reqData0   (reqData0),
    .reqReady0  (reqReady0),
    .reqValid1  (reqValid1),
    .reqAddr1   (reqAddr1),
    .reqData1   (reqData1),
    .reqReady1  (reqReady1),
    .regWrite   (regWrite),
    .decOut     (decOut),
    .writeData  (writeData),
    .stallCount (stallCount)
  );

`ifdef WB_RR_PRIORITY_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        r0;
    logic        r1;
    logic        wr;
    logic [7:0]  dec;
    logic [15:0] data;
    int          stall;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state of the write port as seen by the register set.
  int          m_last;
  logic        m_wr;
  int          m_dec;
  logic [15:0] m_data;
  int          m_stall;
  int          m_win;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_wr    = 1'b0;
    m_dec   = 0;
    m_data  = 16'h0000;
    m_stall = 0;
  endtask

  // Applies one cycle of inputs right after a falling edge, records what the
  // monitor must see this cycle, then advances the model across the next
  // rising edge.
  task automatic drive_cycle(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                             input logic v1, input logic [2:0] a1, input logic [15:0] d1);
    exp_t e;
    logic r0, r1;
    reqValid0 = v0; reqAddr0 = a0; reqData0 = d0;
    reqValid1 = v1; reqAddr1 = a1; reqData1 = d1;

    m_win = -1;
    if (v0 && !v1)      m_win = 0;
    else if (v1 && !v0) m_win = 1;
    else if (v0 && v1)  m_win = RR ? (1 - m_last) : 1;
    r0 = (m_win == 0);
    r1 = (m_win == 1);

    e.r0 = r0; e.r1 = r1; e.wr = m_wr; e.dec = 8'(m_dec);
    e.data = m_data; e.stall = m_stall;
    exp_q.push_back(e);

    if (m_win >= 0) begin
      m_wr   = 1'b1;
      m_dec  = 2 ** ((m_win == 1) ? int'(a1) : int'(a0));
      m_data = (m_win == 1) ? d1 : d0;
      m_last = m_win;
    end else begin
      m_wr  = 1'b0;
      m_dec = 0;
    end
    if ((v0 && !r0) || (v1 && !r1)) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  // Accept a write with requester 0, then assert reset asynchronously between
  // edges: the in-flight write and all state must vanish at once.
  task automatic mid_reset();
    reqValid0 = 1'b1; reqAddr0 = 3'd6; reqData0 = 16'hCAFE;
    reqValid1 = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_regWrite", int'(regWrite), 0);
    chk("rst_decOut", int'(decOut), 0);
    chk("rst_writeData", int'(writeData), 0);
    chk("rst_stallCount", int'(stallCount), 0);
    chk("rst_reqReady0", int'(reqReady0), 0);
    @(negedge clk);
    reset = 1'b0;
    reqValid0 = 1'b0;
    model_reset();
  endtask

  // Monitor: pops one expectation per cycle, mid-way through the low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reqReady0", int'(reqReady0), int'(e.r0));
        chk("reqReady1", int'(reqReady1), int'(e.r1));
        chk("regWrite", int'(regWrite), int'(e.wr));
        chk("decOut", int'(decOut), int'(e.dec));
        chk("writeData", int'(writeData), int'(e.data));
        chk("stallCount", int'(stallCount), e.stall);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        p0, p1;
    logic [2:0]  ra0, ra1;
    logic [15:0] rd0, rd1;
    int          loser;

    reset = 1'b1;
    reqValid0 = 1'b1; reqAddr0 = 3'd0; reqData0 = 16'h0;
    reqValid1 = 1'b0; reqAddr1 = 3'd0; reqData1 = 16'h0;
    #2;
    chk("init_regWrite", int'(regWrite), 0);
    chk("init_decOut", int'(decOut), 0);
    chk("init_writeData", int'(writeData), 0);
    chk("init_stallCount", int'(stallCount), 0);
    chk("init_reqReady0", int'(reqReady0), 0);
    @(negedge clk);
    reset = 1'b0;
    reqValid0 = 1'b0;
    model_reset();

    // Single requester write to register 3.
    drive_cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    idle(2);

    // Tie from fresh reset, addr0=1, addr1=2.
    mid_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 3'd1, 16'(i), 1'b1, 3'd2, 16'(16'h100 + i));
    idle(2);

    // Same-address conflict; the loser retries next cycle.
    mid_reset();
    drive_cycle(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222);
    loser = 1 - m_last;
    if (loser == 0) drive_cycle(1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, 16'h0);
    else            drive_cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h2222);
    idle(2);

    // Persistent contention long enough to saturate the stall counter.
    mid_reset();
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 3'd4, 16'hA5A5, 1'b1, 3'd7, 16'h5A5A);
    idle(2);

    // Random traffic with requesters that hold their request until accepted.
    mid_reset();
    p0 = 1'b0; p1 = 1'b0;
    ra0 = 3'd0; ra1 = 3'd0; rd0 = 16'h0; rd1 = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom_range(0, 99) < 60)) begin
        p0 = 1'b1; ra0 = 3'($urandom_range(0, 7)); rd0 = 16'($urandom);
      end
      if (!p1 && ($urandom_range(0, 99) < 60)) begin
        p1 = 1'b1; ra1 = 3'($urandom_range(0, 7)); rd1 = 16'($urandom);
      end
      drive_cycle(p0, ra0, rd0, p1, ra1, rd1);
      if (m_win == 0) p0 = 1'b0;
      if (m_win == 1) p1 = 1'b0;
    end
    idle(3);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
